// File: rtl/riscV_unrn_pkg.sv
// Shared types and constants for the riscV_unrn core: CSR operations,
// CSR addresses, trap cause codes and mstatus field layout.
package riscV_unrn_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    CSRRNOP = 2'd0,
    CSRRW   = 2'd1,
    CSRRS   = 2'd2,
    CSRRC   = 2'd3
  } csr_op_t;

  typedef logic [11:0] csr_num_t;

  localparam csr_num_t CSR_MSTATUS  = 12'h300;
  localparam csr_num_t CSR_MIE      = 12'h304;
  localparam csr_num_t CSR_MTVEC    = 12'h305;
  localparam csr_num_t CSR_MSCRATCH = 12'h340;
  localparam csr_num_t CSR_MEPC     = 12'h341;
  localparam csr_num_t CSR_MCAUSE   = 12'h342;
  localparam csr_num_t CSR_MTVAL    = 12'h343;
  localparam csr_num_t CSR_MIP      = 12'h344;

  // Interrupt causes carry bit31 set; exceptions have it clear
  localparam logic [31:0] M_SW_INT              = 32'h8000_0003;
  localparam logic [31:0] M_TIMER_INT           = 32'h8000_0007;
  localparam logic [31:0] M_EXT_INT             = 32'h8000_000B;
  localparam logic [31:0] EXC_INSTR_MISALIGNED  = 32'h0000_0000;
  localparam logic [31:0] EXC_ILLEGAL_INSTR     = 32'h0000_0002;
  localparam logic [31:0] EXC_BREAKPOINT        = 32'h0000_0003;
  localparam logic [31:0] EXC_LOAD_MISALIGNED   = 32'h0000_0004;
  localparam logic [31:0] EXC_STORE_MISALIGNED  = 32'h0000_0006;
  localparam logic [31:0] EXC_ECALL_M           = 32'h0000_000B;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_LO   = 11;
  localparam int unsigned MSTATUS_MPP_HI   = 12;

  localparam logic [XLEN-1:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [XLEN-1:0] MSTATUS_FIXED = 32'h0000_1800;
  localparam logic [XLEN-1:0] MIE_WMASK     = 32'h0000_0888;
  localparam logic [XLEN-1:0] MIP_WMASK     = 32'h0000_0888;
  localparam logic [XLEN-1:0] ALIGN4_MASK   = 32'hFFFF_FFFC;

  // Only MSIE/MTIE/MEIE exist; any other cause index is never enabled
  function automatic logic irq_enabled(input logic [XLEN-1:0] mie, input logic [4:0] idx);
    case (idx)
      5'd3:    return mie[3];
      5'd7:    return mie[7];
      5'd11:   return mie[11];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_unit.sv
// Machine-mode CSR file: executes CSR read/modify/write ops and records
// trap state (mepc/mcause/mtval, mstatus stacking) when a trap is taken.
module csr_unit
  import riscV_unrn_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  csr_op_t         op_i,
  input  csr_num_t        address_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] data_o,
  input  logic [31:0]     pc_i,
  input  logic            excRequest_i,
  input  logic [31:0]     excCause_i,
  output logic            exc_o,
  input  logic [31:0]     trapInfo_i
);

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mip_q, mip_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] wval;

  // rd_i is informational; pc_i[1:0] is dropped by mepc alignment
  logic unused_ok;
  assign unused_ok = ^{rd_i, pc_i[1:0]};

  always_comb begin
    data_o = '0;
    case (address_i)
      CSR_MSTATUS:  data_o = mstatus_q;
      CSR_MIE:      data_o = mie_q;
      CSR_MIP:      data_o = mip_q;
      CSR_MTVEC:    data_o = mtvec_q;
      CSR_MSCRATCH: data_o = mscratch_q;
      CSR_MEPC:     data_o = mepc_q;
      CSR_MCAUSE:   data_o = mcause_q;
      CSR_MTVAL:    data_o = mtval_q;
      default:      data_o = '0;
    endcase
  end

  always_comb begin
    if (excCause_i[31])
      exc_o = excRequest_i & mstatus_q[MSTATUS_MIE_BIT] & irq_enabled(mie_q, excCause_i[4:0]);
    else
      exc_o = excRequest_i;
  end

  always_comb begin
    wval = data_o;
    case (op_i)
      CSRRW:   wval = data_i;
      CSRRS:   wval = data_o | data_i;
      CSRRC:   wval = data_o & ~data_i;
      default: wval = data_o;
    endcase
  end

  // A taken trap squashes the CSR instruction, so it has priority over the write
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mip_d      = mip_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (exc_o) begin
      mepc_d    = {pc_i[31:2], 2'b00};
      mcause_d  = excCause_i;
      mtval_d   = trapInfo_i;
      mstatus_d = MSTATUS_FIXED;
      mstatus_d[MSTATUS_MPIE_BIT] = mstatus_q[MSTATUS_MIE_BIT];
    end else if (op_i != CSRRNOP) begin
      case (address_i)
        CSR_MSTATUS:  mstatus_d  = (wval & MSTATUS_WMASK) | MSTATUS_FIXED;
        CSR_MIE:      mie_d      = wval & MIE_WMASK;
        CSR_MIP:      mip_d      = wval & MIP_WMASK;
        CSR_MTVEC:    mtvec_d    = wval & ALIGN4_MASK;
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = wval & ALIGN4_MASK;
        CSR_MCAUSE:   mcause_d   = wval;
        CSR_MTVAL:    mtval_d    = wval;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_q  <= MSTATUS_FIXED;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mip_q      <= mip_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: CSR ops, write masks, trap recording,
// interrupt gating, trap-vs-write priority and asynchronous reset.
module tb_csr_unit;
  import riscV_unrn_pkg::*;

  logic            clk;
  logic            rst;
  csr_op_t         op_i;
  csr_num_t        address_i;
  logic [4:0]      rd_i;
  logic [XLEN-1:0] data_i;
  logic [XLEN-1:0] data_o;
  logic [31:0]     pc_i;
  logic            excRequest_i;
  logic [31:0]     excCause_i;
  logic            exc_o;
  logic [31:0]     trapInfo_i;

  int vectors;
  int miscompares;

  csr_unit dut (
    .clk(clk), .rst(rst), .op_i(op_i), .address_i(address_i), .rd_i(rd_i),
    .data_i(data_i), .data_o(data_o), .pc_i(pc_i), .excRequest_i(excRequest_i),
    .excCause_i(excCause_i), .exc_o(exc_o), .trapInfo_i(trapInfo_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input csr_op_t op, input csr_num_t a, input logic [31:0] d,
                       input logic req, input logic [31:0] cause,
                       input logic [31:0] pc, input logic [31:0] tval);
    op_i = op; address_i = a; data_i = d; excRequest_i = req;
    excCause_i = cause; pc_i = pc; trapInfo_i = tval;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    op_i = CSRRNOP; excRequest_i = 1'b0; data_i = '0;
  endtask

  task automatic rd(input csr_num_t a);
    op_i = CSRRNOP; address_i = a; excRequest_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    csr_num_t    addrs[9] = '{CSR_MSTATUS, CSR_MIE, CSR_MIP, CSR_MTVEC, CSR_MSCRATCH,
                              CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, 12'h7C0};
    logic [31:0] exps[9]  = '{32'h1800, 0, 0, 0, 0, 0, 0, 0, 0};
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rd(addrs[i]);
      vectors++;
      if (data_o !== exps[i]) begin
        $display("FAIL reset_read[%03h]: got %08h expected %08h", addrs[i], data_o, exps[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_rw();
    csr_num_t    addrs[3] = '{CSR_MSCRATCH, CSR_MTVEC, CSR_MEPC};
    logic [31:0] full[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    csr_op_t     ops[3]   = '{CSRRW, CSRRC, CSRRS};
    logic [31:0] exp;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        drive(ops[k], addrs[r], 32'hFFFF_FFFF, 1'b0, 0, 0, 0);
        tick();
        exp = (ops[k] == CSRRC) ? 32'h0 : full[r];
        rd(addrs[r]);
        vectors++;
        if (data_o !== exp) begin
          $display("FAIL rw[%03h] op%0d: got %08h expected %08h", addrs[r], k, data_o, exp);
          miscompares++;
        end
      end
    end
    // data_o shows the pre-write value while the op is presented
    drive(CSRRC, CSR_MSCRATCH, 32'h0000_00F0, 1'b0, 0, 0, 0);
    vectors++;
    if (data_o !== 32'hFFFF_FFFF) begin
      $display("FAIL old_value_during_op: got %08h expected ffffffff", data_o);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_masks();
    csr_num_t    addrs[5] = '{CSR_MIE, CSR_MIP, CSR_MIP, CSR_MSTATUS, 12'h7C0};
    csr_op_t     ops[5]   = '{CSRRS, CSRRS, CSRRC, CSRRS, CSRRW};
    logic [31:0] dats[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0008, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps[5]  = '{32'h0888, 32'h0888, 32'h0880, 32'h1888, 32'h0};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], addrs[i], dats[i], 1'b0, 0, 0, 0);
      tick();
      rd(addrs[i]);
      vectors++;
      if (data_o !== exps[i]) begin
        $display("FAIL mask[%0d] %03h: got %08h expected %08h", i, addrs[i], data_o, exps[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_interrupt();
    csr_num_t    addrs[4] = '{CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MSTATUS};
    logic [31:0] exps[4]  = '{32'hAAAA_AAA8, 32'h8000_000B, 32'h5555_5555, 32'h0000_1880};
    drive(CSRRNOP, CSR_MSTATUS, 0, 1'b1, M_EXT_INT, 32'hAAAA_AAAA, 32'h5555_5555);
    vectors++;
    if (exc_o !== 1'b1) begin
      $display("FAIL ext_int_taken: exc_o=%b expected 1", exc_o);
      miscompares++;
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i]);
      vectors++;
      if (data_o !== exps[i]) begin
        $display("FAIL trap_state[%03h]: got %08h expected %08h", addrs[i], data_o, exps[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_disabled();
    csr_num_t    addrs[3]  = '{CSR_MEPC, CSR_MCAUSE, CSR_MSCRATCH};
    logic [31:0] exps[3]   = '{32'hAAAA_AAA8, 32'h8000_000B, 32'h0000_0077};
    csr_num_t    addrs2[4] = '{CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MSTATUS};
    logic [31:0] exps2[4]  = '{32'h0000_0100, 32'h0000_0002, 32'h0000_DEAD, 32'h0000_1800};
    drive(CSRRW, CSR_MSCRATCH, 32'h77, 1'b1, M_EXT_INT, 32'h44, 32'h99);
    vectors++;
    if (exc_o !== 1'b0) begin
      $display("FAIL irq_masked_by_mie: exc_o=%b expected 0", exc_o);
      miscompares++;
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      rd(addrs[i]);
      vectors++;
      if (data_o !== exps[i]) begin
        $display("FAIL masked_no_trap[%03h]: got %08h expected %08h", addrs[i], data_o, exps[i]);
        miscompares++;
      end
    end
    drive(CSRRNOP, CSR_MSTATUS, 0, 1'b1, EXC_ILLEGAL_INSTR, 32'h0000_0103, 32'h0000_DEAD);
    vectors++;
    if (exc_o !== 1'b1) begin
      $display("FAIL sync_exc_taken: exc_o=%b expected 1", exc_o);
      miscompares++;
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      rd(addrs2[i]);
      vectors++;
      if (data_o !== exps2[i]) begin
        $display("FAIL sync_trap_state[%03h]: got %08h expected %08h", addrs2[i], data_o, exps2[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_irq_mask();
    logic [31:0] causes[3] = '{M_EXT_INT, 32'h8000_0005, M_SW_INT};
    logic        exps[3]   = '{1'b0, 1'b0, 1'b1};
    drive(CSRRS, CSR_MSTATUS, 32'h8, 1'b0, 0, 0, 0);
    tick();
    drive(CSRRC, CSR_MIE, 32'h800, 1'b0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(CSRRNOP, CSR_MIE, 0, 1'b1, causes[i], 32'h300, 0);
      vectors++;
      if (exc_o !== exps[i]) begin
        $display("FAIL irq_gate[%08h]: exc_o=%b expected %b", causes[i], exc_o, exps[i]);
        miscompares++;
      end
    end
    drive(CSRRNOP, CSR_MIE, 0, 1'b1, M_TIMER_INT, 32'h300, 0);
    tick();
    rd(CSR_MSTATUS);
    vectors++;
    if (data_o !== 32'h0000_1880) begin
      $display("FAIL mpie_stack: got %08h expected 00001880", data_o);
      miscompares++;
    end
    rd(CSR_MCAUSE);
    vectors++;
    if (data_o !== M_TIMER_INT) begin
      $display("FAIL timer_cause: got %08h expected %08h", data_o, M_TIMER_INT);
      miscompares++;
    end
  endtask

  task automatic test_trap_vs_write();
    drive(CSRRW, CSR_MSCRATCH, 32'h1234, 1'b1, EXC_ILLEGAL_INSTR, 32'h200, 32'h1);
    tick();
    rd(CSR_MSCRATCH);
    vectors++;
    if (data_o !== 32'h77) begin
      $display("FAIL trap_drops_write: got %08h expected 00000077", data_o);
      miscompares++;
    end
    rd(CSR_MEPC);
    vectors++;
    if (data_o !== 32'h200) begin
      $display("FAIL trap_vs_write_mepc: got %08h expected 00000200", data_o);
      miscompares++;
    end
  endtask

  task automatic test_async_reset();
    csr_num_t    addrs[4] = '{CSR_MSCRATCH, CSR_MSTATUS, CSR_MEPC, CSR_MIE};
    logic [31:0] exps[4]  = '{32'h0, 32'h1800, 32'h0, 32'h0};
    drive(CSRRS, CSR_MSTATUS, 32'h8, 1'b0, 0, 0, 0);
    tick();
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i]);
      vectors++;
      if (data_o !== exps[i]) begin
        $display("FAIL async_reset[%03h]: got %08h expected %08h", addrs[i], data_o, exps[i]);
        miscompares++;
      end
    end
    drive(CSRRNOP, CSR_MIE, 0, 1'b1, M_SW_INT, 0, 0);
    vectors++;
    if (exc_o !== 1'b0) begin
      $display("FAIL irq_in_reset: exc_o=%b expected 0", exc_o);
      miscompares++;
    end
    drive(CSRRNOP, CSR_MIE, 0, 1'b1, EXC_ILLEGAL_INSTR, 0, 0);
    vectors++;
    if (exc_o !== 1'b1) begin
      $display("FAIL sync_in_reset: exc_o=%b expected 1", exc_o);
      miscompares++;
    end
    excRequest_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    drive(CSRRW, CSR_MSCRATCH, 32'h5, 1'b0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(CSRRS, CSR_MSCRATCH, 32'hA, 1'b0, 0, 0, 0);
    vectors++;
    if (data_o !== 32'h5) begin
      $display("FAIL b2b_old_value: got %08h expected 00000005", data_o);
      miscompares++;
    end
    tick();
    rd(CSR_MSCRATCH);
    vectors++;
    if (data_o !== 32'hF) begin
      $display("FAIL b2b_result: got %08h expected 0000000f", data_o);
      miscompares++;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    op_i = CSRRNOP;
    address_i = '0;
    rd_i = 5'd1;
    data_i = '0;
    pc_i = '0;
    excRequest_i = 1'b0;
    excCause_i = '0;
    trapInfo_i = '0;
    test_reset();
    test_rw();
    test_masks();
    test_interrupt();
    test_disabled();
    test_irq_mask();
    test_trap_vs_write();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Machine-mode CSR register file for the riscV_unrn core.
- Executes CSR read/modify/write instructions from the datapath.
- Records trap state (mepc, mcause, mtval, mstatus stacking) when the controller requests an exception.
- Reports whether the request is actually taken.

Parameters:
XLEN, 32 (from riscV_unrn_pkg), CSR data width

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
op_i  in  csr_op_t  CSR operation: CSRRNOP, CSRRW, CSRRS, CSRRC
address_i  in  csr_num_t (12)  CSR address
rd_i  in  5  destination register index of the CSR instruction; informational only, no effect on behaviour
data_i  in  XLEN  write/set/clear operand from datapath
data_o  out  XLEN  old value of addressed CSR, combinational
pc_i  in  32  PC of the instruction causing the trap
excRequest_i  in  1  trap request from controller
excCause_i  in  32  cause code; bit31 = interrupt (e.g. M_EXT_INT = 0x8000_000B)
exc_o  out  1  trap taken this cycle, combinational
trapInfo_i  in  32  value for mtval

Behaviour:
- Implemented CSRs; reset values apply on rst low, asynchronously:
  - mstatus 0x300: writable MIE[3], MPIE[7]; MPP[12:11] hardwired 2'b11; other bits 0; reset 0x0000_1800.
  - mie 0x304: writable MSIE[3], MTIE[7], MEIE[11]; reset 0.
  - mip 0x344: writable MSIP[3], MTIP[7], MEIP[11]; reset 0.
  - mtvec 0x305: bits[1:0] hardwired 0 (direct mode); reset 0.
  - mscratch 0x340: full 32 bits; reset 0.
  - mepc 0x341: bits[1:0] hardwired 0; reset 0.
  - mcause 0x342: full 32 bits; reset 0.
  - mtval 0x343: full 32 bits; reset 0.
- data_o:
  - Equals the current (pre-write) value of address_i for every op, including CSRRNOP.
  - Unimplemented address reads 0.
- Write on rising edge when exc_o=0:
  - CSRRW: new = data_i.
  - CSRRS: new = old | data_i.
  - CSRRC: new = old & ~data_i.
  - CSRRNOP: no write.
  - Write masks and hardwired bits are applied after the operation.
  - Writes to unimplemented addresses are ignored.
  - The new value is visible on data_o the cycle after the write.
- exc_o, combinational:
  - excCause_i[31]=0 (synchronous exception): exc_o = excRequest_i.
  - excCause_i[31]=1 (interrupt): exc_o = excRequest_i & mstatus.MIE & mie[excCause_i[4:0]]; cause indices other than 3/7/11 never enable.
- Trap taken (exc_o=1) at the rising edge:
  - mepc <= {pc_i[31:2],2'b00}
  - mcause <= excCause_i
  - mtval <= trapInfo_i
  - mstatus.MPIE <= MIE; MIE <= 0; MPP stays 11.
- Simultaneous trap and CSR write: the trap wins and the CSR write is dropped (the instruction did not retire).
- excRequest_i with interrupt disabled: exc_o=0, no trap state changes, and any CSR op proceeds normally.
- Reset asserted mid-operation: all CSRs return to reset values immediately, independent of clk.
- Outputs during reset: data_o reflects reset register values; exc_o follows the combinational rule using reset state, so only synchronous exceptions can assert it.

Decomposition:
- riscV_unrn_pkg holds:
  - XLEN
  - csr_op_t enum
  - csr_num_t (12-bit) with CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP constants
  - cause constants (M_EXT_INT = 0x8000_000B, M_TIMER_INT = 0x8000_0007, M_SW_INT = 0x8000_0003, exception codes)
  - mstatus bit-position constants
- Single module; no sub-module needed.

Test Plan:
- Reset, then read each CSR with CSRRNOP -> mstatus 0x0000_1800, all others 0x0; no register changes.
- mscratch, data_i=0xFFFF_FFFF: CSRRW -> next read 0xFFFF_FFFF; CSRRC -> 0x0; CSRRS -> 0xFFFF_FFFF. Repeat on mtvec -> reads 0xFFFF_FFFC.
- CSRRS 0xFFFF_FFFF to mie -> 0x0000_0888. Same to mstatus -> 0x0000_1888.
- Interrupts enabled (previous scenario); excRequest_i=1, excCause_i=0x8000_000B, pc_i=0xAAAA_AAAA, trapInfo_i=0x5555_5555 -> exc_o=1. After the edge: mepc=0xAAAA_AAA8, mcause=0x8000_000B, mtval=0x5555_5555, mstatus=0x0000_1880.
- mstatus.MIE=0; request excCause_i=0x8000_000B -> exc_o=0, mepc/mcause unchanged. Request synchronous cause 0x0000_0002 -> exc_o=1 and trap recorded.
- CSRRW mscratch=0x1234 in the same cycle as a taken trap -> mscratch unchanged. Assert rst low mid-cycle -> all CSRs at reset values before the next edge.
